// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data, occupancy count and empty/full flags.
// Optional sticky overflow/underflow outputs are included when FIFO_ERR_FLAGS_EN is defined.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] buf_in,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] buf_out,
    output logic                  buf_empty,
    output logic                  buf_full,
`ifdef FIFO_ERR_FLAGS_EN
    output logic                  overflow,
    output logic                  underflow,
`endif
    output logic [CNT_WIDTH-1:0]  fifo_counter
);
    localparam int PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_WIDTH-1:0]  r_wr_ptr;
    logic [PTR_WIDTH-1:0]  r_rd_ptr;
    logic                  w_write_ok;
    logic                  w_read_ok;

    assign buf_empty  = fifo_counter == '0;
    assign buf_full   = fifo_counter == CNT_WIDTH'(DEPTH);
    assign w_write_ok = wr_en & ~buf_full;
    assign w_read_ok  = rd_en & ~buf_empty;

    // Storage has no reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (w_write_ok) r_mem[r_wr_ptr] <= buf_in;
    end

    // Pointers, read data and occupancy; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            buf_out      <= '0;
            fifo_counter <= '0;
        end else begin
            if (w_write_ok) r_wr_ptr <= r_wr_ptr + PTR_WIDTH'(1);
            if (w_read_ok) begin
                buf_out  <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + PTR_WIDTH'(1);
            end
            if (w_write_ok && !w_read_ok) fifo_counter <= fifo_counter + CNT_WIDTH'(1);
            else if (w_read_ok && !w_write_ok) fifo_counter <= fifo_counter - CNT_WIDTH'(1);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags; a write at full is never rescued by a same-edge read, since acceptance uses pre-edge flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en && buf_full) overflow <= 1'b1;
            if (rd_en && buf_empty) underflow <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed self-checking bench for sync_fifo (default 64x8 geometry).
module tb_sync_fifo;
    logic       clk;
    logic       rst;
    logic [7:0] buf_in;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] buf_out;
    logic       buf_empty;
    logic       buf_full;
    logic [7:0] fifo_counter;
`ifdef FIFO_ERR_FLAGS_EN
    logic       overflow;
    logic       underflow;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    sync_fifo dut (
        .clk(clk),
        .rst(rst),
        .buf_in(buf_in),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .buf_out(buf_out),
        .buf_empty(buf_empty),
        .buf_full(buf_full),
`ifdef FIFO_ERR_FLAGS_EN
        .overflow(overflow),
        .underflow(underflow),
`endif
        .fifo_counter(fifo_counter)
    );

    // Posedges fall at 10, 20, 30 ... so the 15 ns reset release is clear of any edge.
    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given requests; returns 1 ns after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        wr_en  = w;
        rd_en  = r;
        buf_in = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buf_in = 8'h00;
        #2;
        chk("rst_cnt", fifo_counter, 0);
        chk("rst_empty", buf_empty, 1);
        chk("rst_full", buf_full, 0);
        chk("rst_out", buf_out, 0);
        #13 rst = 1'b1;
        cyc(1, 0, 8'hA1); cyc(1, 0, 8'hB2); cyc(1, 0, 8'hC3); cyc(1, 0, 8'hD4);
        chk("wr4_cnt", fifo_counter, 4);
        chk("wr4_empty", buf_empty, 0);
        chk("wr4_full", buf_full, 0);
        chk("wr4_out", buf_out, 8'h00);
`ifdef FIFO_ERR_FLAGS_EN
        chk("wr4_ovf", overflow, 0);
        chk("wr4_unf", underflow, 0);
`endif
        cyc(0, 1, 0); chk("rd_a1", buf_out, 8'hA1);
        cyc(0, 1, 0); chk("rd_b2", buf_out, 8'hB2);
        chk("rd2_cnt", fifo_counter, 2);
        cyc(1, 1, 8'hE5); chk("rw_c3", buf_out, 8'hC3); chk("rw_cnt1", fifo_counter, 2);
        cyc(1, 1, 8'hF6); chk("rw_d4", buf_out, 8'hD4); chk("rw_cnt2", fifo_counter, 2);
        cyc(0, 1, 0); chk("dr_e5", buf_out, 8'hE5);
        cyc(0, 1, 0); chk("dr_f6", buf_out, 8'hF6);
        cyc(0, 1, 0); chk("dr_hold", buf_out, 8'hF6);
        chk("dr_cnt", fifo_counter, 0);
        chk("dr_empty", buf_empty, 1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("dr_unf", underflow, 1);
`endif
        // Read+write on empty: write only, no fall-through to buf_out.
        cyc(1, 1, 8'h77); chk("ew_out", buf_out, 8'hF6); chk("ew_cnt", fifo_counter, 1);
        cyc(0, 1, 0); chk("ew_rd", buf_out, 8'h77); chk("ew_cnt0", fifo_counter, 0);
        for (int i = 0; i < 64; i++) cyc(1, 0, 8'(i));
        chk("fill_cnt", fifo_counter, 64);
        chk("fill_full", buf_full, 1);
        chk("fill_empty", buf_empty, 0);
        cyc(1, 0, 8'hFF);
        chk("ovw_cnt", fifo_counter, 64);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovw_ovf", overflow, 1);
`endif
        cyc(0, 1, 0); chk("wrap_00", buf_out, 8'h00); chk("wrap_cnt63", fifo_counter, 63);
        cyc(1, 0, 8'h40); chk("wrap_cnt64", fifo_counter, 64);
        // Read+write on full: read only, write dropped.
        cyc(1, 1, 8'hEE); chk("fr_01", buf_out, 8'h01); chk("fr_cnt", fifo_counter, 63);
        for (int i = 2; i < 64; i++) begin
            cyc(0, 1, 0);
            chk($sformatf("wrap_%02h", i), buf_out, 32'(i));
        end
        cyc(0, 1, 0); chk("wrap_40", buf_out, 8'h40);
        chk("wrap_cnt0", fifo_counter, 0);
        chk("wrap_empty", buf_empty, 1);
        cyc(0, 1, 0); chk("wrap_hold", buf_out, 8'h40);
        cyc(1, 0, 8'h11); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33);
        chk("mid_cnt3", fifo_counter, 3);
        rst = 1'b0;
        #1;
        chk("mid_cnt", fifo_counter, 0);
        chk("mid_empty", buf_empty, 1);
        chk("mid_full", buf_full, 0);
        chk("mid_out", buf_out, 0);
`ifdef FIFO_ERR_FLAGS_EN
        chk("mid_ovf", overflow, 0);
        chk("mid_unf", underflow, 0);
`endif
        #2 rst = 1'b1;
        cyc(1, 0, 8'h5A); chk("post_cnt", fifo_counter, 1);
        cyc(0, 1, 0); chk("post_out", buf_out, 8'h5A);
        chk("post_cnt0", fifo_counter, 0);
        cyc(0, 1, 0); chk("post_hold", buf_out, 8'h5A);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock, synchronous-read FIFO buffer for byte-wide data. Default geometry is 64 entries of 8 bits.
- Reports occupancy count plus empty and full flags.
- Used as a generic elastic buffer between a producer and a consumer in the same clock domain.

Parameters:
- DATA_WIDTH, 8: width of buf_in / buf_out.
- DEPTH, 64: number of storage entries; must be a power of two, 2..128.
- CNT_WIDTH, 8: width of fifo_counter; must satisfy 2^CNT_WIDTH > DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset (0 = reset asserted).
- buf_in  in  DATA_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- buf_out  out  DATA_WIDTH  registered read data.
- buf_empty  out  1  high when occupancy = 0.
- buf_full  out  1  high when occupancy = DEPTH.
- fifo_counter  out  CNT_WIDTH  current occupancy (0..DEPTH).

Behaviour:
- Reset (rst=0, asynchronous, no clock needed):
  - buf_out=0, fifo_counter=0, read/write pointers=0.
  - buf_empty=1, buf_full=0.
  - Storage array is not cleared.
  - All state holds its reset value for as long as rst=0.
- Flags are decoded combinationally from the registered fifo_counter: buf_empty=(count==0), buf_full=(count==DEPTH).
- Acceptance is evaluated on the pre-edge flags:
  - write_ok = wr_en & ~buf_full.
  - read_ok = rd_en & ~buf_empty.
- Write, on clk rising edge with write_ok:
  - mem[wr_ptr] <= buf_in.
  - wr_ptr advances by 1, wrapping modulo DEPTH.
- Read, on clk rising edge with read_ok:
  - buf_out <= mem[rd_ptr].
  - rd_ptr advances by 1, wrapping modulo DEPTH.
  - Data is visible on buf_out right after that edge (1-cycle latency from rd_en sampled).
- buf_out holds its last value whenever read_ok=0.
- Counter update per edge:
  - +1 if write_ok only.
  - -1 if read_ok only.
  - Unchanged if both or neither.
- Simultaneous rd_en & wr_en:
  - Non-empty and non-full: both operations occur; count is unchanged.
  - Empty: only the write occurs. The read is dropped and there is no fall-through; count becomes 1.
  - Full: only the read occurs. The write is dropped; count becomes DEPTH-1.
- Write when full is ignored silently: no pointer, memory or count change.
- Read when empty is ignored silently: buf_out unchanged.
- Order is strict FIFO across pointer wrap-around.
- Reset asserted mid-operation discards all contents immediately. The first write after release lands at entry 0.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added: overflow and underflow, each 1 bit.
  - overflow becomes 1 on the edge where wr_en=1 and buf_full=1, and the write is not also allowed by a simultaneous read.
  - underflow becomes 1 on the edge where rd_en=1 and buf_empty=1.
  - Both are sticky until rst=0, and both reset to 0.
- When not defined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset then write: hold rst=0 for 15 ns, then release. Write A1, B2, C3, D4 on consecutive edges -> fifo_counter=4, buf_empty=0, buf_full=0, buf_out=00.
- Read two: rd_en for 2 edges -> buf_out=A1 then B2, fifo_counter=2.
- Simultaneous: wr_en=rd_en=1 with buf_in E5 then F6 -> buf_out=C3 then D4, fifo_counter stays 2.
- Drain past empty: rd_en for 3 edges -> buf_out=E5, F6, then holds F6; fifo_counter=0, buf_empty=1.
- Fill and wrap:
  - Write 64 values 00..3F -> buf_full=1, fifo_counter=64.
  - A 65th write of FF is ignored.
  - Read 1, write 40, then drain -> outputs 01..3F, 40 in order.
  - With FIFO_ERR_FLAGS_EN, overflow=1 after the FF attempt.
- Reset mid-stream: with 3 entries stored, pulse rst=0 between edges -> immediately fifo_counter=0, buf_empty=1, buf_out=00; a subsequent write/read returns the new data only.
